// File: rtl/meter_pkg.sv
// Shared meter definitions: fixed-point scale, default widths, scheduler
// state encoding and the accumulator width rule.
package meter_pkg;

    localparam int FRAC_SCALE    = 1000;
    localparam int DEF_NUM_LOADS = 4;
    localparam int DEF_RATE_W    = 16;
    localparam int DEF_BAL_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DIVIDE,
        DEBIT
    } sched_state_t;

    // Accumulator holds a sub-unit remainder (< FRAC_SCALE) plus one full tick
    // of summed rates; two guard bits keep that sum from overflowing.
    function automatic int ACC_W(input int rate_w, input int num_loads);
        return rate_w + $clog2(num_loads) + 2;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Consumption tick generator: one-cycle pulse every TICK_DIV cycles,
// frozen (no pulse, count held) while pause is high.
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pause,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: wrap after the last value, hold while paused.
    always_comb begin
        cnt_d = cnt_q;
        if (!pause) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = !pause && (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/consumption_scheduler.sv
// Consumption scheduler: grants/sheds loads from the balance, sums granted
// rates once per tick into a milli-unit accumulator, converts whole units
// and hands one debit per tick to the balance owner over valid/ready.
module consumption_scheduler
    import meter_pkg::*;
#(
    parameter int NUM_LOADS      = DEF_NUM_LOADS,
    parameter int TICK_DIV       = 1000000,
    parameter int RATE_W         = DEF_RATE_W,
    parameter int BAL_W          = DEF_BAL_W,
    parameter int SHED_THRESHOLD = 40,
    parameter int SHED_HYST      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LOADS-1:0]        load_req,
    input  logic [NUM_LOADS*RATE_W-1:0] load_rate,
    input  logic [BAL_W-1:0]            balance,
    input  logic                        pause,
    output logic [NUM_LOADS-1:0]        load_grant,
    output logic                        debit_valid,
    output logic [BAL_W-1:0]            debit_amount,
    input  logic                        debit_ready,
    output logic                        tick,
    output logic                        shed_active,
    output logic                        tick_overrun
);

    localparam int IDX_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
    localparam int SUM_W = RATE_W + IDX_W;
    localparam int AW    = ACC_W(RATE_W, NUM_LOADS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOADS - 1);
    localparam logic [AW-1:0]    FRAC_AW  = AW'(FRAC_SCALE);
    localparam logic [BAL_W-1:0] SHED_SET = BAL_W'(SHED_THRESHOLD);
    localparam logic [BAL_W-1:0] SHED_CLR = BAL_W'(SHED_THRESHOLD + SHED_HYST);

    // Unit counter never wraps; excess conversions stick at all-ones.
    function automatic logic [BAL_W-1:0] sat_inc(input logic [BAL_W-1:0] v);
        return (v == '1) ? v : v + BAL_W'(1);
    endfunction

    // A debit never exceeds what the balance can cover.
    function automatic logic [BAL_W-1:0] clamp_to(input logic [BAL_W-1:0] u,
                                                  input logic [BAL_W-1:0] b);
        return (u > b) ? b : u;
    endfunction

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SUM_W-1:0]      sum_q, sum_d, sum_next;
    logic [AW-1:0]         acc_q, acc_d;
    logic [BAL_W-1:0]      units_q, units_d;
    logic [NUM_LOADS-1:0]  snap_q, snap_d;
    logic [NUM_LOADS-1:0]  grant_q, grant_d;
    logic                  shed_q, shed_d;
    logic                  dv_q, dv_d;
    logic [BAL_W-1:0]      da_q, da_d;
    logic                  overrun_q, overrun_d;
    logic [RATE_W-1:0]     rate_sel;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .pause (pause),
        .tick  (tick)
    );

    assign rate_sel = load_rate[idx_q*RATE_W +: RATE_W];

    // Shed hysteresis and per-load grant decision (essential load 0 ignores shed).
    always_comb begin
        shed_d = shed_q;
        if (balance < SHED_SET)       shed_d = 1'b1;
        else if (balance >= SHED_CLR) shed_d = 1'b0;
        grant_d = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            grant_d[i] = load_req[i] && (balance != '0) && ((i == 0) || !shed_q);
        end
    end

    // Charge-cycle FSM: snapshot, scan rates, divide into units, debit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        acc_d     = acc_q;
        units_d   = units_q;
        snap_d    = snap_q;
        dv_d      = dv_q;
        da_d      = da_q;
        sum_next  = sum_q + (snap_q[idx_q] ? SUM_W'(rate_sel) : SUM_W'(0));
        overrun_d = overrun_q || (tick && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_d  = grant_q;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    acc_d   = acc_q + AW'(sum_next);
                    units_d = '0;
                    state_d = DIVIDE;
                end else begin
                    sum_d = sum_next;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DIVIDE: begin
                if (acc_q >= FRAC_AW) begin
                    acc_d   = acc_q - FRAC_AW;
                    units_d = sat_inc(units_q);
                end else if (units_q == '0) begin
                    state_d = IDLE;
                end else begin
                    da_d    = clamp_to(units_q, balance);
                    dv_d    = 1'b1;
                    state_d = DEBIT;
                end
            end
            DEBIT: begin
                if (debit_ready) begin
                    dv_d    = 1'b0;
                    da_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any charge in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sum_q     <= '0;
            acc_q     <= '0;
            units_q   <= '0;
            snap_q    <= '0;
            grant_q   <= '0;
            shed_q    <= 1'b0;
            dv_q      <= 1'b0;
            da_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            acc_q     <= acc_d;
            units_q   <= units_d;
            snap_q    <= snap_d;
            grant_q   <= grant_d;
            shed_q    <= shed_d;
            dv_q      <= dv_d;
            da_q      <= da_d;
            overrun_q <= overrun_d;
        end
    end

    assign load_grant   = grant_q;
    assign shed_active  = shed_q;
    assign debit_valid  = dv_q;
    assign debit_amount = da_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_consumption_scheduler.sv
// Directed bench for consumption_scheduler with a short tick period.
module tb_consumption_scheduler;

    localparam int NL = 4;
    localparam int RW = 16;
    localparam int BW = 16;
    localparam int TD = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NL-1:0]  load_req = '0;
    logic [NL*RW-1:0] load_rate = '0;
    logic [BW-1:0]  balance = '0;
    logic           pause = 1'b0;
    logic [NL-1:0]  load_grant;
    logic           debit_valid;
    logic [BW-1:0]  debit_amount;
    logic           debit_ready = 1'b0;
    logic           tick;
    logic           shed_active;
    logic           tick_overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int last_tick_cyc = 0;
    int prev_tick_cyc = 0;
    logic [BW-1:0] debits[$];

    consumption_scheduler #(
        .NUM_LOADS(NL), .TICK_DIV(TD), .RATE_W(RW), .BAL_W(BW),
        .SHED_THRESHOLD(40), .SHED_HYST(5)
    ) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_rate(load_rate),
        .balance(balance), .pause(pause), .load_grant(load_grant),
        .debit_valid(debit_valid), .debit_amount(debit_amount),
        .debit_ready(debit_ready), .tick(tick), .shed_active(shed_active),
        .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    // Observe ticks and completed debit handshakes away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (tick) begin
            prev_tick_cyc = last_tick_cyc;
            last_tick_cyc = cyc;
            tick_cnt++;
        end
        if (debit_valid && debit_ready) debits.push_back(debit_amount);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        debits.delete();
    endtask

    task automatic set_rates(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                             input logic [RW-1:0] r2, input logic [RW-1:0] r3);
        load_rate = {r3, r2, r1, r0};
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = tick_cnt + n;
        guard = 0;
        while (tick_cnt < target && guard < 200) begin
            step(1);
            guard++;
        end
        vectors++;
        if (tick_cnt < target) begin
            miscompares++;
            $display("FAIL wait_ticks: got %0d ticks, required %0d", tick_cnt, target);
        end
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (!debit_valid && guard < 40) begin
            step(1);
            guard++;
        end
        vectors++;
        if (!debit_valid) begin
            miscompares++;
            $display("FAIL wait_valid: debit_valid never rose");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        balance = 100;
        load_req = '1;
        step(3);
        vectors++;
        if ({load_grant, debit_valid, debit_amount, tick, shed_active, tick_overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: grant=%b dv=%b amt=%0d tick=%b shed=%b ovr=%b required all 0",
                     load_grant, debit_valid, debit_amount, tick, shed_active, tick_overrun);
        end
    endtask

    task automatic test_single_load();
        do_reset();
        balance = 100; load_req = 4'b0001; set_rates(500, 0, 0, 0); debit_ready = 1'b1;
        vectors++;
        if (load_grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL grant_latency_before: got %b required 0000", load_grant);
        end
        step(1);
        vectors++;
        if (load_grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL grant_latency_after: got %b required 0001", load_grant);
        end
        wait_ticks(4);
        step(12);
        vectors++;
        if (last_tick_cyc - prev_tick_cyc !== TD) begin
            miscompares++;
            $display("FAIL tick_period: got %0d required %0d", last_tick_cyc - prev_tick_cyc, TD);
        end
        vectors++;
        if (debits.size() !== 2) begin
            miscompares++;
            $display("FAIL single_debit_count: got %0d required 2", debits.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (debits[i] !== 16'd1) begin
                    miscompares++;
                    $display("FAIL single_debit_amt[%0d]: got %0d required 1", i, debits[i]);
                end
            end
        end
    endtask

    task automatic test_all_loads();
        logic [BW-1:0] exp_d[5];
        exp_d = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
        do_reset();
        balance = 100; load_req = 4'b1111; set_rates(300, 300, 300, 300); debit_ready = 1'b1;
        step(1);
        vectors++;
        if (load_grant !== 4'b1111) begin
            miscompares++;
            $display("FAIL all_grants: got %b required 1111", load_grant);
        end
        wait_ticks(5);
        step(12);
        vectors++;
        if (debits.size() !== 5) begin
            miscompares++;
            $display("FAIL all_debit_count: got %0d required 5", debits.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (debits[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL all_debit_amt[%0d]: got %0d required %0d", i, debits[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_shed();
        logic [BW-1:0] bal_v[5];
        logic          shed_v[5];
        logic [NL-1:0] grant_v[5];
        bal_v   = '{16'd50, 16'd39, 16'd44, 16'd40, 16'd45};
        shed_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        grant_v = '{4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b1111};
        do_reset();
        load_req = 4'b1111; set_rates(0, 0, 0, 0); debit_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            balance = bal_v[i];
            step(3);
            vectors++;
            if (shed_active !== shed_v[i] || load_grant !== grant_v[i]) begin
                miscompares++;
                $display("FAIL shed_bal%0d: shed=%b grant=%b required shed=%b grant=%b",
                         bal_v[i], shed_active, load_grant, shed_v[i], grant_v[i]);
            end
        end
    endtask

    task automatic test_balance_limit();
        do_reset();
        balance = 1; load_req = 4'b0001; set_rates(5000, 0, 0, 0); debit_ready = 1'b1;
        wait_ticks(1);
        step(12);
        vectors++;
        if (debits.size() !== 1 || debits[0] !== 16'd1) begin
            miscompares++;
            $display("FAIL clamp_debit: count=%0d first=%0d required count=1 amount=1",
                     debits.size(), (debits.size() > 0) ? debits[0] : 16'd0);
        end
        balance = 0;
        step(2);
        vectors++;
        if (load_grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_balance_grant: got %b required 0000", load_grant);
        end
        wait_ticks(2);
        step(12);
        vectors++;
        if (debits.size() !== 1) begin
            miscompares++;
            $display("FAIL zero_balance_debits: got %0d required 1", debits.size());
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        balance = 100; load_req = 4'b0001; set_rates(1000, 0, 0, 0); debit_ready = 1'b0;
        wait_ticks(1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            step(1);
            vectors++;
            if (debit_valid !== 1'b1 || debit_amount !== 16'd1) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: dv=%b amt=%0d required dv=1 amt=1",
                         i, debit_valid, debit_amount);
            end
        end
        vectors++;
        if (tick_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got %b required 1", tick_overrun);
        end
        vectors++;
        if (debits.size() !== 0) begin
            miscompares++;
            $display("FAIL early_debit: got %0d required 0", debits.size());
        end
        load_req = '0;
        debit_ready = 1'b1;
        step(1);
        vectors++;
        if (debits.size() !== 1 || debit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release: count=%0d dv=%b required count=1 dv=0", debits.size(), debit_valid);
        end
    endtask

    task automatic test_pause_reset();
        int t0;
        int n;
        do_reset();
        balance = 100; load_req = 4'b0001; set_rates(1500, 0, 0, 0); debit_ready = 1'b0;
        step(3);
        pause = 1'b1;
        t0 = tick_cnt;
        step(30);
        vectors++;
        if (tick_cnt !== t0) begin
            miscompares++;
            $display("FAIL pause_ticks: got %0d ticks required 0", tick_cnt - t0);
        end
        pause = 1'b0;
        n = 0;
        @(negedge clk);
        while (!tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== 12) begin
            miscompares++;
            $display("FAIL pause_resume: tick after %0d cycles required 12", n);
        end
        step(1);
        wait_valid();
        reset = 1'b1;
        step(1);
        vectors++;
        if ({load_grant, debit_valid, debit_amount, tick, shed_active, tick_overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_debit: grant=%b dv=%b amt=%0d ovr=%b required all 0",
                     load_grant, debit_valid, debit_amount, tick_overrun);
        end
        reset = 1'b0;
        debits.delete();
        set_rates(500, 0, 0, 0);
        debit_ready = 1'b1;
        wait_ticks(1);
        step(12);
        vectors++;
        if (debits.size() !== 0) begin
            miscompares++;
            $display("FAIL acc_cleared: got %0d debits required 0", debits.size());
        end
        wait_ticks(1);
        step(12);
        vectors++;
        if (debits.size() !== 1 || debits[0] !== 16'd1) begin
            miscompares++;
            $display("FAIL post_reset_debit: count=%0d required count=1 amount=1", debits.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_all_loads();
        test_shed();
        test_balance_limit();
        test_back_pressure();
        test_pause_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
